// File: rtl/ro_meter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ro_meter_pkg                                                               |
// | Shared types and constants for the ring-oscillator frequency meter.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ro_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } meter_state_t;

  localparam int SYNC_STAGES = 2;
  localparam int ARM_CYCLES  = 2;
  localparam int ARM_CNT_W   = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_edge_detect                                                           |
// | Synchronizes an asynchronous input and emits a one-cycle rising-edge pulse.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sync_edge_detect
  import ro_meter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise = r_sync[SYNC_STAGES-1] & ~r_dly;

endmodule
`default_nettype wire

// File: rtl/ro_freq_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ro_freq_meter                                                              |
// | Counts divided ring-oscillator rising edges over a programmable clk window.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int GATE_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ro_clk_in,
  input  logic              start,
  input  logic              cont,
  input  logic [GATE_W-1:0] gate_len,
  output logic              busy,
  output logic              valid,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  meter_state_t         r_state;
  logic [GATE_W-1:0]    r_gate_len;
  logic [GATE_W-1:0]    r_gate_cnt;
  logic [ARM_CNT_W-1:0] r_arm_cnt;
  logic [CNT_W-1:0]     r_edge_cnt;
  logic                 r_sat;
  logic                 r_busy;
  logic                 r_valid;
  logic [CNT_W-1:0]     r_count;
  logic                 r_overflow;

  logic                 w_rise;
  logic                 w_at_max;
  logic                 w_gate_last;
  logic [CNT_W-1:0]     w_edge_final;
  logic                 w_sat_final;

  sync_edge_detect u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ro_clk_in),
    .rise     (w_rise)
  );

  // The final GATE cycle's edge must land in the published result, so the
  // result is taken from the counter's next value rather than its current one.
  assign w_at_max     = &r_edge_cnt;
  assign w_edge_final = (w_rise && !w_at_max) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
  assign w_sat_final  = r_sat | (w_rise & w_at_max);
  assign w_gate_last  = (r_gate_cnt == GATE_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gate_len <= '0;
      r_gate_cnt <= '0;
      r_arm_cnt  <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_gate_len <= (gate_len == '0) ? GATE_W'(1) : gate_len;
            r_arm_cnt  <= '0;
            r_busy     <= 1'b1;
            r_state    <= ARM;
          end
        end
        ARM: begin
          r_edge_cnt <= '0;
          r_sat      <= 1'b0;
          r_gate_cnt <= r_gate_len;
          if (r_arm_cnt == ARM_CNT_W'(ARM_CYCLES - 1)) begin
            r_state <= GATE;
          end else begin
            r_arm_cnt <= r_arm_cnt + ARM_CNT_W'(1);
          end
        end
        GATE: begin
          if (w_rise) begin
            if (w_at_max) begin
              r_sat <= 1'b1;
            end else begin
              r_edge_cnt <= r_edge_cnt + CNT_W'(1);
            end
          end
          if (w_gate_last) begin
            r_count    <= w_edge_final;
            r_overflow <= w_sat_final;
            r_valid    <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_gate_cnt <= r_gate_cnt - GATE_W'(1);
          end
        end
        DONE: begin
          if (cont) begin
            r_arm_cnt <= '0;
            r_state   <= ARM;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign valid    = r_valid;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ro_freq_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ro_freq_meter                                                           |
// | Randomized self-checking bench for ro_freq_meter (16-bit and 4-bit count). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ro_freq_meter;

  logic        clk;
  logic        rst;
  logic        ro_clk_in;
  logic        start;
  logic        cont;
  logic [15:0] gate_len;

  logic        busy16, valid16, ovf16;
  logic [15:0] count16;
  logic        busy4, valid4, ovf4;
  logic [3:0]  count4;

  int n_tests = 0;
  int n_fail  = 0;
  int ro_period = 0;

  ro_freq_meter #(.GATE_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ro_clk_in(ro_clk_in), .start(start), .cont(cont),
    .gate_len(gate_len), .busy(busy16), .valid(valid16), .count(count16),
    .overflow(ovf16)
  );

  ro_freq_meter #(.GATE_W(16), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ro_clk_in(ro_clk_in), .start(start), .cont(cont),
    .gate_len(gate_len), .busy(busy4), .valid(valid4), .count(count4),
    .overflow(ovf4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Toggles land on a 2 ns offset grid, never on a clk edge.
  initial begin
    ro_clk_in = 1'b0;
    #2;
    forever begin
      if (ro_period == 0) begin
        ro_clk_in = 1'b0;
        #5;
      end else begin
        ro_clk_in = ~ro_clk_in;
        #(ro_period * 5);
      end
    end
  end

  task automatic run_meas(input int gl, input int per,
                          output int valid_cyc, output int n_valid,
                          output int busy_on, output int busy_off,
                          output logic [15:0] c16, output logic o16,
                          output logic [3:0] c4, output logic o4);
    ro_period = per;
    repeat (25 + $urandom_range(0, 7)) @(negedge clk);
    gate_len = 16'(gl);
    start = 1'b1;
    valid_cyc = -1; n_valid = 0; busy_on = -1; busy_off = -1;
    c16 = '0; o16 = 1'b0; c4 = '0; o4 = 1'b0;
    for (int k = 1; k <= gl + 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (busy16 && busy_on < 0) busy_on = k;
      if (!busy16 && busy_on >= 0 && busy_off < 0) busy_off = k;
      if (valid16) begin
        n_valid++;
        if (valid_cyc < 0) begin
          valid_cyc = k; c16 = count16; o16 = ovf16; c4 = count4; o4 = ovf4;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cont = 1'b0; gate_len = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy16, valid16, ovf16, count16} !== 19'd0) begin
      n_fail++; $display("FAIL reset_outputs16: got %0h expected 0", {busy16, valid16, ovf16, count16});
    end
    n_tests++;
    if ({busy4, valid4, ovf4, count4} !== 7'd0) begin
      n_fail++; $display("FAIL reset_outputs4: got %0h expected 0", {busy4, valid4, ovf4, count4});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy16 !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: busy got %0b expected 0", busy16);
    end
  endtask

  task automatic test_basic();
    int vc, nv, bon, boff, d;
    logic [15:0] c16; logic o16; logic [3:0] c4; logic o4;
    run_meas(100, 10, vc, nv, bon, boff, c16, o16, c4, o4);
    n_tests++; if (vc !== 103) begin n_fail++; $display("FAIL basic_latency: got %0d expected 103", vc); end
    n_tests++; if (nv !== 1) begin n_fail++; $display("FAIL basic_valid_count: got %0d expected 1", nv); end
    n_tests++; if (bon !== 1) begin n_fail++; $display("FAIL basic_busy_on: got %0d expected 1", bon); end
    n_tests++; if (boff !== 104) begin n_fail++; $display("FAIL basic_busy_off: got %0d expected 104", boff); end
    d = int'(c16) * 10 - 100;
    n_tests++; if (d < -10 || d > 10) begin n_fail++; $display("FAIL basic_count: got %0d expected 10+-1", c16); end
    n_tests++; if (o16 !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %0b expected 0", o16); end
  endtask

  task automatic test_no_input();
    int vc, nv, bon, boff;
    logic [15:0] c16; logic o16; logic [3:0] c4; logic o4;
    run_meas(50, 0, vc, nv, bon, boff, c16, o16, c4, o4);
    n_tests++; if (vc !== 53) begin n_fail++; $display("FAIL noin_latency: got %0d expected 53", vc); end
    n_tests++; if (c16 !== 16'd0) begin n_fail++; $display("FAIL noin_count: got %0d expected 0", c16); end
    n_tests++; if (o16 !== 1'b0) begin n_fail++; $display("FAIL noin_overflow: got %0b expected 0", o16); end
  endtask

  task automatic test_gate_zero();
    int vc, nv, bon, boff;
    logic [15:0] c16; logic o16; logic [3:0] c4; logic o4;
    run_meas(0, 0, vc, nv, bon, boff, c16, o16, c4, o4);
    n_tests++; if (vc !== 4) begin n_fail++; $display("FAIL gate0_latency: got %0d expected 4", vc); end
    n_tests++; if (boff !== 5) begin n_fail++; $display("FAIL gate0_busy_off: got %0d expected 5", boff); end
    n_tests++; if (c16 !== 16'd0) begin n_fail++; $display("FAIL gate0_count: got %0d expected 0", c16); end
  endtask

  task automatic test_saturation();
    int vc, nv, bon, boff, d;
    logic [15:0] c16; logic o16; logic [3:0] c4; logic o4;
    run_meas(100, 4, vc, nv, bon, boff, c16, o16, c4, o4);
    n_tests++; if (c4 !== 4'd15) begin n_fail++; $display("FAIL sat_count4: got %0d expected 15", c4); end
    n_tests++; if (o4 !== 1'b1) begin n_fail++; $display("FAIL sat_overflow4: got %0b expected 1", o4); end
    d = int'(c16) * 4 - 100;
    n_tests++; if (d < -4 || d > 4) begin n_fail++; $display("FAIL sat_count16: got %0d expected 25+-1", c16); end
    n_tests++; if (o16 !== 1'b0) begin n_fail++; $display("FAIL sat_overflow16: got %0b expected 0", o16); end
    run_meas(20, 4, vc, nv, bon, boff, c16, o16, c4, o4);
    d = int'(c4) * 4 - 20;
    n_tests++; if (d < -4 || d > 4) begin n_fail++; $display("FAIL unsat_count4: got %0d expected 5+-1", c4); end
    n_tests++; if (o4 !== 1'b0) begin n_fail++; $display("FAIL unsat_overflow4: got %0b expected 0", o4); end
    n_tests++; if (vc !== 23) begin n_fail++; $display("FAIL unsat_latency: got %0d expected 23", vc); end
  endtask

  task automatic test_random();
    int vc, nv, bon, boff, d, gl, per, n;
    logic [15:0] c16; logic o16; logic [3:0] c4; logic o4;
    for (int i = 0; i < 6; i++) begin
      gl  = $urandom_range(20, 250);
      per = $urandom_range(4, 16);
      n   = gl;
      run_meas(gl, per, vc, nv, bon, boff, c16, o16, c4, o4);
      n_tests++; if (vc !== n + 3) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, vc, n + 3); end
      n_tests++; if (boff !== n + 4) begin n_fail++; $display("FAIL rand_busy_off[%0d]: got %0d expected %0d", i, boff, n + 4); end
      d = int'(c16) * per - n;
      n_tests++;
      if (d < -per || d > per) begin
        n_fail++; $display("FAIL rand_count[%0d]: got %0d expected %0d/%0d +-1", i, c16, n, per);
      end
      n_tests++; if (o16 !== 1'b0) begin n_fail++; $display("FAIL rand_overflow[%0d]: got %0b expected 0", i, o16); end
    end
  endtask

  task automatic test_cont();
    int vcyc[$];
    int vcnt[$];
    int busy40;
    int exp_cyc[3] = '{13, 26, 39};
    ro_period = 5;
    repeat (25) @(negedge clk);
    cont = 1'b1; gate_len = 16'd10; start = 1'b1;
    busy40 = -1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 5) begin start = 1'b1; gate_len = 16'd3; end
      if (k == 6) start = 1'b0;
      if (k == 30) cont = 1'b0;
      if (k == 40) busy40 = int'(busy16);
      if (valid16) begin vcyc.push_back(k); vcnt.push_back(int'(count16)); end
    end
    n_tests++;
    if (vcyc.size() !== 3) begin
      n_fail++; $display("FAIL cont_strobes: got %0d expected 3", vcyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (vcyc[i] !== exp_cyc[i]) begin
          n_fail++; $display("FAIL cont_cycle[%0d]: got %0d expected %0d", i, vcyc[i], exp_cyc[i]);
        end
        n_tests++;
        if (vcnt[i] < 1 || vcnt[i] > 3) begin
          n_fail++; $display("FAIL cont_count[%0d]: got %0d expected 2+-1", i, vcnt[i]);
        end
      end
    end
    n_tests++; if (busy40 !== 0) begin n_fail++; $display("FAIL cont_idle: busy got %0d expected 0", busy40); end
  endtask

  task automatic test_reset_mid();
    int vc, nv, bon, boff, d;
    logic [15:0] c16; logic o16; logic [3:0] c4; logic o4;
    ro_period = 7;
    repeat (25) @(negedge clk);
    gate_len = 16'd100; start = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    n_tests++; if (busy16 !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %0b expected 1", busy16); end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({busy16, valid16, ovf16, count16} !== 19'd0) begin
      n_fail++; $display("FAIL rmid_async_clear: got %0h expected 0", {busy16, valid16, ovf16, count16});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (busy16 !== 1'b0 || valid16 !== 1'b0) begin
      n_fail++; $display("FAIL rmid_idle: busy/valid got %0b%0b expected 00", busy16, valid16);
    end
    run_meas(60, 6, vc, nv, bon, boff, c16, o16, c4, o4);
    n_tests++; if (vc !== 63) begin n_fail++; $display("FAIL rmid_latency: got %0d expected 63", vc); end
    d = int'(c16) * 6 - 60;
    n_tests++; if (d < -6 || d > 6) begin n_fail++; $display("FAIL rmid_count: got %0d expected 10+-1", c16); end
    n_tests++; if (o16 !== 1'b0) begin n_fail++; $display("FAIL rmid_overflow: got %0b expected 0", o16); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_input();
    test_gate_zero();
    test_saturation();
    test_random();
    test_cont();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
